// File: rtl/vga_timing_monitor.sv
// Passive video timing checker: measures line/frame geometry from HSync/VSync,
// tracks lock, keeps sticky error flags and a per-frame RGB checksum.
module vga_timing_monitor #(
  parameter int unsigned VIDEO_WIDTH = 3,
  parameter int unsigned TOTAL_COLS  = 10,
  parameter int unsigned TOTAL_ROWS  = 6,
  parameter int unsigned ACTIVE_COLS = 8,
  parameter int unsigned ACTIVE_ROWS = 4,
  parameter int unsigned LOCK_FRAMES = 2,
  parameter int unsigned SUM_WIDTH   = 16
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_L,
  input  logic                   i_HSync,
  input  logic                   i_VSync,
  input  logic [VIDEO_WIDTH-1:0] i_Red_Video,
  input  logic [VIDEO_WIDTH-1:0] i_Grn_Video,
  input  logic [VIDEO_WIDTH-1:0] i_Blu_Video,
  input  logic                   i_Clear_Err,
  output logic                   o_Locked,
  output logic [3:0]             o_Err,
  output logic [SUM_WIDTH-1:0]   o_Frame_Sum,
  output logic                   o_Frame_Valid
);
  localparam int unsigned CYC_MAX  = 2 * TOTAL_COLS;
  localparam int unsigned CYC_W    = $clog2(CYC_MAX + 1);
  localparam int unsigned LINE_MAX = 2 * TOTAL_ROWS;
  localparam int unsigned LINE_W   = $clog2(LINE_MAX + 1);
  localparam int unsigned GOOD_W   = $clog2(LOCK_FRAMES + 1);
  localparam int unsigned PIX_W    = 3 * VIDEO_WIDTH;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t               state;
  logic                 h_prev;
  logic                 v_prev;
  logic [CYC_W-1:0]     cyc_cnt;
  logic [CYC_W-1:0]     hs_width;
  logic [LINE_W-1:0]    line_cnt;
  logic [LINE_W-1:0]    act_cnt;
  logic [GOOD_W-1:0]    good_cnt;
  logic                 frame_bad;
  logic [SUM_WIDTH-1:0] acc;

  logic                 h_rise;
  logic                 h_fall;
  logic                 v_rise;
  logic                 checking;
  logic                 line_start;
  logic                 timeout;
  logic [3:0]           err_det;
  logic [PIX_W-1:0]     pix_raw;
  logic [SUM_WIDTH-1:0] pix_c;

  // Edge detection and per-cycle error detection
  always_comb begin
    h_rise     = i_HSync & ~h_prev;
    h_fall     = ~i_HSync & h_prev;
    v_rise     = i_VSync & ~v_prev;
    checking   = (state != HUNT);
    // The V-rise that leaves HUNT also starts the first measured line
    line_start = h_rise | (~checking & v_rise);
    timeout    = checking & ~h_rise & (cyc_cnt == CYC_W'(CYC_MAX));
    err_det    = '0;
    err_det[0] = checking & ((h_rise & (cyc_cnt != CYC_W'(TOTAL_COLS))) | timeout);
    err_det[1] = checking & h_fall & (hs_width != CYC_W'(ACTIVE_COLS));
    err_det[2] = checking & v_rise & (line_cnt != LINE_W'(TOTAL_ROWS));
    err_det[3] = checking & v_rise & (act_cnt != LINE_W'(ACTIVE_ROWS));
    pix_raw    = {i_Red_Video, i_Grn_Video, i_Blu_Video};
    pix_c      = (i_HSync & i_VSync) ? SUM_WIDTH'(pix_raw) : '0;
  end

  // Geometry counters and checksum accumulator
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      h_prev   <= 1'b0;
      v_prev   <= 1'b0;
      cyc_cnt  <= '0;
      hs_width <= '0;
      line_cnt <= '0;
      act_cnt  <= '0;
      acc      <= '0;
    end else begin
      h_prev <= i_HSync;
      v_prev <= i_VSync;
      acc    <= v_rise ? pix_c : acc + pix_c;
      if (!checking && !v_rise) begin
        cyc_cnt  <= '0;
        hs_width <= '0;
        line_cnt <= '0;
        act_cnt  <= '0;
      end else begin
        if (line_start) begin
          cyc_cnt <= CYC_W'(1);
        end else if (cyc_cnt != CYC_W'(CYC_MAX)) begin
          cyc_cnt <= cyc_cnt + CYC_W'(1);
        end
        if (line_start) begin
          hs_width <= CYC_W'(1);
        end else if (i_HSync && (hs_width != CYC_W'(CYC_MAX))) begin
          hs_width <= hs_width + CYC_W'(1);
        end
        if (v_rise) begin
          line_cnt <= LINE_W'(h_rise);
          act_cnt  <= LINE_W'(h_rise);
        end else if (h_rise) begin
          if (line_cnt != LINE_W'(LINE_MAX)) line_cnt <= line_cnt + LINE_W'(1);
          if (i_VSync && (act_cnt != LINE_W'(LINE_MAX))) act_cnt <= act_cnt + LINE_W'(1);
        end
      end
    end
  end

  // Lock state machine with registered status outputs
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state         <= HUNT;
      good_cnt      <= '0;
      frame_bad     <= 1'b0;
      o_Locked      <= 1'b0;
      o_Err         <= '0;
      o_Frame_Sum   <= '0;
      o_Frame_Valid <= 1'b0;
    end else begin
      o_Frame_Valid <= checking & v_rise;
      if (checking && v_rise) o_Frame_Sum <= acc;
      o_Err <= (o_Err & ~{4{i_Clear_Err}}) | err_det;
      case (state)
        HUNT: begin
          if (v_rise) begin
            state     <= MEASURE;
            good_cnt  <= '0;
            frame_bad <= 1'b0;
          end
        end
        default: begin
          if (timeout) begin
            state    <= HUNT;
            good_cnt <= '0;
            o_Locked <= 1'b0;
          end else if (|err_det) begin
            // An error at the closing V-rise condemns the old frame, not the new one
            state     <= MEASURE;
            good_cnt  <= '0;
            frame_bad <= ~v_rise;
            o_Locked  <= 1'b0;
          end else if (v_rise) begin
            frame_bad <= 1'b0;
            if (!frame_bad) begin
              if (good_cnt >= GOOD_W'(LOCK_FRAMES - 1)) begin
                state    <= LOCKED;
                good_cnt <= GOOD_W'(LOCK_FRAMES);
                o_Locked <= 1'b1;
              end else begin
                good_cnt <= good_cnt + GOOD_W'(1);
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Self-checking bench for vga_timing_monitor: directed video with a
// cycle-level reference model plus literal timing/checksum expectations.
module tb_vga_timing_monitor;
  localparam int TC = 10;
  localparam int TR = 6;
  localparam int AC = 8;
  localparam int AR = 4;
  localparam int LF = 2;

  logic        clk;
  logic        rst_n;
  logic        hsync;
  logic        vsync;
  logic [2:0]  red;
  logic [2:0]  grn;
  logic [2:0]  blu;
  logic        clear_err;
  logic        locked;
  logic [3:0]  err;
  logic [15:0] frame_sum;
  logic        frame_valid;

  vga_timing_monitor dut (
    .i_Clk        (clk),
    .i_Rst_L      (rst_n),
    .i_HSync      (hsync),
    .i_VSync      (vsync),
    .i_Red_Video  (red),
    .i_Grn_Video  (grn),
    .i_Blu_Video  (blu),
    .i_Clear_Err  (clear_err),
    .o_Locked     (locked),
    .o_Err        (err),
    .o_Frame_Sum  (frame_sum),
    .o_Frame_Valid(frame_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic clr_req;
  logic ramp;
  int   pk;

  // Markers for the literal latency checks after the first reset release
  int   t0 = -1;
  int   first_valid = -1;
  int   first_lock = -1;
  int   first_sum = -1;
  logic vin_prev = 1'b0;

  // Reference model state
  int          m_mode;
  int          m_last_rise;
  int          m_wstart;
  int          m_lines;
  int          m_act;
  int          m_good;
  bit          m_bad;
  int unsigned m_acc;
  logic        m_hsp;
  logic        m_vsp;
  logic [3:0]  m_err;
  logic        m_locked;
  logic        m_valid;
  logic [15:0] m_sum;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_last_rise = 0; m_wstart = 0; m_lines = 0; m_act = 0;
    m_good = 0; m_bad = 0; m_acc = 0; m_hsp = 1'b0; m_vsp = 1'b0;
    m_err = '0; m_locked = 1'b0; m_valid = 1'b0; m_sum = '0;
  endtask

  // Applies the timing rules to the inputs of cycle 'cyc'
  task automatic model_step(input logic hs, input logic vs, input logic [8:0] pix, input logic clr);
    bit hr, hf, vr, to;
    logic [3:0] det;
    int since, width;
    int unsigned pv;
    hr = hs && !m_hsp;
    hf = !hs && m_hsp;
    vr = vs && !m_vsp;
    det = '0;
    to = 0;
    m_valid = 1'b0;
    if (m_mode == 0) begin
      if (vr) begin
        m_mode = 1; m_good = 0; m_bad = 0;
        m_last_rise = cyc; m_wstart = cyc;
        m_lines = hr ? 1 : 0; m_act = hr ? 1 : 0;
      end
    end else begin
      since = cyc - m_last_rise;
      if (since > 2 * TC) since = 2 * TC;
      width = cyc - m_wstart;
      if (width > 2 * TC) width = 2 * TC;
      if (hr && since != TC) det[0] = 1'b1;
      if (!hr && since == 2 * TC) begin to = 1; det[0] = 1'b1; end
      if (hf && width != AC) det[1] = 1'b1;
      if (vr && m_lines != TR) det[2] = 1'b1;
      if (vr && m_act != AR) det[3] = 1'b1;
      if (vr) begin m_valid = 1'b1; m_sum = m_acc[15:0]; end
      if (hr) begin m_last_rise = cyc; m_wstart = cyc; end
      if (vr) begin
        m_lines = hr ? 1 : 0; m_act = hr ? 1 : 0;
      end else if (hr) begin
        m_lines++;
        if (vs) m_act++;
      end
      if (to) begin
        m_mode = 0; m_good = 0;
      end else if (det != 0) begin
        m_good = 0; m_bad = !vr; m_mode = 1;
      end else if (vr) begin
        if (!m_bad) begin
          m_good++;
          if (m_good >= LF) m_mode = 2;
        end
        m_bad = 0;
      end
    end
    pv = (hs && vs) ? 32'(pix) : 32'd0;
    m_acc = vr ? pv : ((m_acc + pv) & 32'hFFFF);
    m_err = (clr ? 4'b0000 : m_err) | det;
    m_locked = (m_mode == 2);
    m_hsp = hs;
    m_vsp = vs;
  endtask

  // Compare DUT against the model every cycle, then advance the model
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        model_reset();
        t0 = -1; first_valid = -1; first_lock = -1; first_sum = -1;
        vin_prev = 1'b0;
      end
      chk("locked", 32'(locked), 32'(m_locked));
      chk("err", 32'(err), 32'(m_err));
      chk("frame_valid", 32'(frame_valid), 32'(m_valid));
      chk("frame_sum", 32'(frame_sum), 32'(m_sum));
      if (rst_n) begin
        if (frame_valid && first_valid < 0) begin
          first_valid = cyc; first_sum = int'(frame_sum);
        end
        if (locked && first_lock < 0) first_lock = cyc;
        if (vsync && !vin_prev && t0 < 0) t0 = cyc;
        vin_prev = vsync;
        model_step(hsync, vsync, {red, grn, blu}, clear_err);
      end
    end
  end

  task automatic tick(input logic hs, input logic vs);
    @(posedge clk);
    #1;
    hsync = hs;
    vsync = vs;
    clear_err = clr_req;
    clr_req = 1'b0;
    if (ramp) begin
      red = 3'(pk); grn = 3'(pk >> 1); blu = 3'(pk + 3); pk++;
    end else begin
      red = 3'b001; grn = 3'b001; blu = 3'b001;
    end
  endtask

  task automatic line(input int hi, input int lo, input logic vs);
    for (int i = 0; i < hi; i++) tick(1'b1, vs);
    for (int i = 0; i < lo; i++) tick(1'b0, vs);
  endtask

  task automatic frame_mod(input int act, input int tot, input int mline, input int mhi, input int mlo);
    for (int l = 0; l < tot; l++) begin
      if (l == mline) line(mhi, mlo, l < act);
      else line(AC, TC - AC, l < act);
    end
  endtask

  task automatic frame(input int act, input int tot);
    frame_mod(act, tot, -1, AC, TC - AC);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected stimulus to complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; hsync = 1'b0; vsync = 1'b0;
    red = '0; grn = '0; blu = '0;
    clear_err = 1'b0; clr_req = 1'b0; ramp = 1'b0; pk = 0;

    // Reset held while syncs toggle, released mid-line in blanking
    line(8, 2, 1'b1); line(8, 2, 1'b1); line(8, 2, 1'b0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_sum", 32'(frame_sum), 32'd0);
    chk("rst_valid", 32'(frame_valid), 32'd0);
    repeat (3) tick(1'b1, 1'b0);
    rst_n = 1'b1;
    repeat (5) tick(1'b1, 1'b0);
    repeat (2) tick(1'b0, 1'b0);
    line(8, 2, 1'b0);

    // Ideal timing with pixel 73: sum 2336 at t0+61, lock at t0+121
    repeat (3) frame(4, 6);
    chk("lat_first_valid", 32'(first_valid - t0), 32'd61);
    chk("first_sum", 32'(first_sum), 32'd2336);
    chk("lat_first_lock", 32'(first_lock - t0), 32'd121);
    chk("ideal_err", 32'(err), 32'd0);
    chk("ideal_locked", 32'(locked), 32'd1);
    chk("ideal_sum", 32'(frame_sum), 32'd2336);

    // Short line (9 cycles)
    frame_mod(4, 6, 1, 8, 1);
    chk("short_err", 32'(err), 32'd1);
    chk("short_locked", 32'(locked), 32'd0);
    repeat (3) frame(4, 6);
    chk("short_relock", 32'(locked), 32'd1);
    chk("short_sticky", 32'(err), 32'd1);
    clr_req = 1'b1;
    frame(4, 6);
    chk("short_cleared", 32'(err), 32'd0);

    // HSync stretched to 9 cycles, line becomes 11
    frame_mod(4, 6, 1, 9, 2);
    chk("stretch_err", 32'(err), 32'd3);
    chk("stretch_locked", 32'(locked), 32'd0);
    clr_req = 1'b1;
    repeat (3) frame(4, 6);
    chk("stretch_relock", 32'(locked), 32'd1);
    chk("stretch_cleared", 32'(err), 32'd0);

    // VSync 3 lines in a 6-line frame, then a 5-line frame
    frame(3, 6);
    frame(4, 6);
    chk("vwidth_err", 32'(err), 32'd8);
    clr_req = 1'b1;
    frame(4, 5);
    frame(4, 6);
    chk("flen_err", 32'(err), 32'd4);

    // Ramped pixels while relocking
    clr_req = 1'b1;
    ramp = 1'b1;
    repeat (3) frame(4, 6);
    ramp = 1'b0;
    chk("ramp_locked", 32'(locked), 32'd1);
    chk("ramp_err", 32'(err), 32'd0);

    // HSync held low: timeout 20 cycles after the last H-rise, clear coincident
    for (int l = 0; l < 4; l++) line(8, 2, 1'b1);
    line(8, 2, 1'b0);
    repeat (8) tick(1'b1, 1'b0);
    repeat (12) tick(1'b0, 1'b0);
    clr_req = 1'b1;
    tick(1'b0, 1'b0);
    repeat (10) tick(1'b0, 1'b0);
    chk("timeout_err", 32'(err), 32'd1);
    chk("timeout_locked", 32'(locked), 32'd0);
    repeat (3) frame(4, 6);
    chk("timeout_relock", 32'(locked), 32'd1);

    // Reset asserted mid-frame discards the partial frame
    for (int l = 0; l < 4; l++) line(8, 2, 1'b1);
    line(8, 2, 1'b0);
    repeat (3) tick(1'b1, 1'b0);
    rst_n = 1'b0;
    repeat (3) tick(1'b1, 1'b0);
    chk("midrst_locked", 32'(locked), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    chk("midrst_sum", 32'(frame_sum), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick(1'b1, 1'b0);
    repeat (2) tick(1'b0, 1'b0);
    repeat (2) frame(4, 6);
    chk("post_rst_sum", 32'(frame_sum), 32'd2336);
    chk("post_rst_locked", 32'(locked), 32'd0);
    chk("post_rst_err", 32'(err), 32'd0);

    repeat (3) tick(1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
